// File: rtl/ir_packet_tx.sv
// ir_packet_tx: IR packet transmitter, start/car/command bursts gated on a carrier.
// Define IR_TX_AUTO_REPEAT_EN to add the REPEAT input for back-to-back packets.
module ir_packet_tx #(
  parameter int CARRIER_HALF   = 2778,
  parameter int START_BURST    = 192,
  parameter int GAP_SIZE       = 24,
  parameter int ASSERT_BURST   = 48,
  parameter int DEASSERT_BURST = 24,
  parameter int NUM_CMD_BITS   = 4,
  parameter int CNT_W          = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    ENABLE,
  input  logic [NUM_CMD_BITS-1:0] COMMAND,
  input  logic [CNT_W-1:0]        CAR_BURST,
  input  logic                    SEND_PACKET,
`ifdef IR_TX_AUTO_REPEAT_EN
  input  logic                    REPEAT,
`endif
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    IR_LED
);

  localparam int CW =
    (CARRIER_HALF > 0) ? $clog2(CARRIER_HALF + 1) : 1;
  localparam int IW =
    (NUM_CMD_BITS > 1) ? $clog2(NUM_CMD_BITS) : 1;

  localparam logic [CW-1:0]    CH       = CW'(CARRIER_HALF);
  localparam logic [CNT_W-1:0] START_SZ = CNT_W'(START_BURST);
  localparam logic [CNT_W-1:0] GAP_SZ   = CNT_W'(GAP_SIZE);
  localparam logic [CNT_W-1:0] ASRT_SZ  = CNT_W'(ASSERT_BURST);
  localparam logic [CNT_W-1:0] DSRT_SZ  = CNT_W'(DEASSERT_BURST);
  localparam logic [IW-1:0]    LAST_IDX = IW'(NUM_CMD_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, SGAP, CAR, CGAP, BIT, BGAP
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    carrier;
  logic                    carrier_dly;
  logic                    tick;
  logic                    rst;
  logic                    rpt;
  logic                    led_en;
  logic                    busy_q;
  logic                    done_q;
  logic [CNT_W-1:0]        bc;
  logic [CNT_W-1:0]        size;
  logic [IW-1:0]           idx;
  logic [NUM_CMD_BITS-1:0] cmd_q;
  logic [CNT_W-1:0]        car_q;
  logic                    in_burst;

  assign rst  = RESET | ~ENABLE;
  assign tick = carrier_dly & ~carrier;

`ifdef IR_TX_AUTO_REPEAT_EN
  assign rpt = REPEAT;
`else
  assign rpt = 1'b0;
`endif

  assign in_burst = (state == START) ||
                    (state == CAR) ||
                    (state == BIT);

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign IR_LED = carrier & led_en;

  // Free-running carrier divider; tick marks each carrier falling edge.
  always_ff @(posedge CLK) begin
    if (rst) begin
      cnt         <= '0;
      carrier     <= 1'b0;
      carrier_dly <= 1'b0;
    end else begin
      carrier_dly <= carrier;
      if (cnt == CH) begin
        cnt     <= '0;
        carrier <= ~carrier;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Length of the current state in carrier periods.
  always_comb begin
    size = GAP_SZ;
    unique case (state)
      START:   size = START_SZ;
      CAR:     size = car_q;
      BIT:     size = cmd_q[idx] ? ASRT_SZ : DSRT_SZ;
      default: size = GAP_SZ;
    endcase
  end

  // Packet sequencer with registered BUSY/DONE/led_en.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state  <= IDLE;
      bc     <= '0;
      idx    <= '0;
      cmd_q  <= '0;
      car_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      led_en <= 1'b0;
    end else begin
      done_q <= 1'b0;
      led_en <= in_burst;
      if (state == IDLE) begin
        if (SEND_PACKET) begin
          cmd_q  <= COMMAND;
          car_q  <= CAR_BURST;
          bc     <= '0;
          idx    <= '0;
          busy_q <= 1'b1;
          state  <= START;
        end
      end else if (bc == size) begin
        bc <= '0;
        unique case (state)
          START: state <= SGAP;
          SGAP:  state <= CAR;
          CAR:   state <= CGAP;
          CGAP:  state <= BIT;
          BIT:   state <= BGAP;
          default: begin
            if (idx != LAST_IDX) begin
              idx   <= idx + 1'b1;
              state <= BIT;
            end else begin
              done_q <= 1'b1;
              idx    <= '0;
              if (rpt) begin
                cmd_q <= COMMAND;
                car_q <= CAR_BURST;
                state <= START;
              end else begin
                busy_q <= 1'b0;
                state  <= IDLE;
              end
            end
          end
        endcase
      end else if (tick) begin
        bc <= bc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ir_packet_tx.sv
// tb_ir_packet_tx: directed bench for ir_packet_tx with a short carrier.
// Define IR_TX_AUTO_REPEAT_EN to include the auto-repeat scenario.
module tb_ir_packet_tx;

  logic       CLK;
  logic       RESET;
  logic       ENABLE;
  logic [3:0] COMMAND;
  logic [7:0] CAR_BURST;
  logic       SEND_PACKET;
`ifdef IR_TX_AUTO_REPEAT_EN
  logic       REPEAT;
`endif
  logic       BUSY;
  logic       DONE;
  logic       IR_LED;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int start  = 0;

  logic mon_clr = 1'b1;
  logic prev_led;
  int   grp [16];
  int   ngrp;
  int   low_run;
  int   busy_n;
  int   done_n;
  int   done_cyc;

  ir_packet_tx #(
    .CARRIER_HALF  (3),
    .START_BURST   (4),
    .GAP_SIZE      (2),
    .ASSERT_BURST  (3),
    .DEASSERT_BURST(1),
    .NUM_CMD_BITS  (4),
    .CNT_W         (8)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .COMMAND    (COMMAND),
    .CAR_BURST  (CAR_BURST),
    .SEND_PACKET(SEND_PACKET),
`ifdef IR_TX_AUTO_REPEAT_EN
    .REPEAT     (REPEAT),
`endif
    .BUSY       (BUSY),
    .DONE       (DONE),
    .IR_LED     (IR_LED)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Cycles since the last reset edge; carrier phase follows from it.
  always @(posedge CLK) begin
    if (RESET || !ENABLE) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Groups IR_LED pulses; a low run of 8+ samples starts a new group.
  always @(negedge CLK) begin
    if (mon_clr) begin
      ngrp     <= 0;
      low_run  <= 99;
      busy_n   <= 0;
      done_n   <= 0;
      done_cyc <= -1;
      prev_led <= 1'b0;
      for (int i = 0; i < 16; i++) grp[i] <= 0;
    end else begin
      if (IR_LED && !prev_led) begin
        if (ngrp == 0 || low_run >= 8) begin
          if (ngrp < 16) grp[ngrp] <= 1;
          ngrp <= ngrp + 1;
        end else if (ngrp <= 16) begin
          grp[ngrp-1] <= grp[ngrp-1] + 1;
        end
      end
      low_run  <= IR_LED ? 0 : low_run + 1;
      prev_led <= IR_LED;
      if (BUSY) busy_n <= busy_n + 1;
      if (DONE) begin
        if (done_n == 0) done_cyc <= cyc;
        done_n <= done_n + 1;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_groups(input string tag, input int base,
                            input int n, input int g [6]);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_grp%0d", tag, base + i),
          grp[base+i], g[i]);
  endtask

  task automatic clear_mon();
    @(posedge CLK);
    #1 mon_clr = 1'b1;
    @(posedge CLK);
    #1 mon_clr = 1'b0;
  endtask

  // Request on a tick cycle so START begins 1 CLK after a carrier fall.
  task automatic send();
    do @(negedge CLK); while (cyc % 8 != 0);
    SEND_PACKET = 1'b1;
    @(negedge CLK);
    SEND_PACKET = 1'b0;
    start = cyc;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  initial begin
    RESET       = 1'b1;
    ENABLE      = 1'b1;
    COMMAND     = 4'b0000;
    CAR_BURST   = 8'd0;
    SEND_PACKET = 1'b1;
`ifdef IR_TX_AUTO_REPEAT_EN
    REPEAT      = 1'b0;
`endif

    // T1: reset held with a request pending
    repeat (3) begin
      @(negedge CLK);
      chk("t1_led", int'(IR_LED), 0);
      chk("t1_busy", int'(BUSY), 0);
      chk("t1_done", int'(DONE), 0);
    end
    SEND_PACKET = 1'b0;
    RESET       = 1'b0;
    wait_cyc(3);
    chk("t1_idle_busy", int'(BUSY), 0);
    chk("t1_idle_led", int'(IR_LED), 0);

    // T2: command 0101, car burst 2
    clear_mon();
    COMMAND   = 4'b0101;
    CAR_BURST = 8'd2;
    send();
    chk("t2_busy_start", int'(BUSY), 1);
    wait_cyc(230);
    chk("t2_ngrp", ngrp, 6);
    chk_groups("t2", 0, 6, '{4, 2, 3, 1, 3, 1});
    chk("t2_done_n", done_n, 1);
    chk("t2_done_cyc", done_cyc - start, 209);
    chk("t2_busy_n", busy_n, 209);

    // T3: zero car burst, command 0000
    clear_mon();
    COMMAND   = 4'b0000;
    CAR_BURST = 8'd0;
    send();
    wait_cyc(190);
    chk("t3_ngrp", ngrp, 5);
    chk_groups("t3", 0, 5, '{4, 1, 1, 1, 1, 0});
    chk("t3_done_n", done_n, 1);
    chk("t3_busy_n", busy_n, 161);

    // T4: reset during the first command burst
    clear_mon();
    COMMAND   = 4'b0101;
    CAR_BURST = 8'd2;
    send();
    repeat (84) @(negedge CLK);
    chk("t4_led_pre", int'(IR_LED), 1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("t4_led_abort", int'(IR_LED), 0);
    chk("t4_busy_abort", int'(BUSY), 0);
    chk("t4_done_abort", int'(DONE), 0);
    RESET = 1'b0;
    wait_cyc(200);
    chk("t4_done_none", done_n, 0);
    chk("t4_busy_idle", int'(BUSY), 0);
    clear_mon();
    send();
    wait_cyc(230);
    chk("t4_ngrp", ngrp, 6);
    chk_groups("t4", 0, 6, '{4, 2, 3, 1, 3, 1});
    chk("t4_done_n", done_n, 1);

    // T5: inputs changed and request re-pulsed mid-packet
    clear_mon();
    COMMAND   = 4'b1100;
    CAR_BURST = 8'd1;
    send();
    repeat (40) @(negedge CLK);
    COMMAND     = 4'b0011;
    CAR_BURST   = 8'd3;
    SEND_PACKET = 1'b1;
    @(negedge CLK);
    SEND_PACKET = 1'b0;
    wait_cyc(300);
    chk("t5_ngrp", ngrp, 6);
    chk_groups("t5", 0, 6, '{4, 1, 1, 1, 3, 3});
    chk("t5_done_n", done_n, 1);
    chk("t5_busy_n", busy_n, 201);

`ifdef IR_TX_AUTO_REPEAT_EN
    // T6: auto-repeat gives two back-to-back packets
    clear_mon();
    REPEAT    = 1'b1;
    COMMAND   = 4'b1000;
    CAR_BURST = 8'd2;
    send();
    repeat (250) @(negedge CLK);
    REPEAT = 1'b0;
    wait_cyc(220);
    chk("t6_ngrp", ngrp, 12);
    chk_groups("t6a", 0, 6, '{4, 2, 1, 1, 1, 3});
    chk_groups("t6b", 6, 6, '{4, 2, 1, 1, 1, 3});
    chk("t6_done_n", done_n, 2);
    chk("t6_done_cyc", done_cyc - start, 193);
    chk("t6_busy_n", busy_n, 385);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
